// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: jump condition codes, status flag
// bit positions, sequencer states and the condition evaluator.
package pc_seq_pkg;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_EQ     = 3'd1;
  localparam logic [2:0] COND_NE     = 3'd2;
  localparam logic [2:0] COND_GT     = 3'd3;
  localparam logic [2:0] COND_GE     = 3'd4;
  localparam logic [2:0] COND_LT     = 3'd5;
  localparam logic [2:0] COND_LE     = 3'd6;
  localparam logic [2:0] COND_CS     = 3'd7;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  function automatic logic cond_true(input logic [2:0] cond, input logic [3:0] flags);
    logic z, n, c;
    z = flags[FLAG_Z];
    n = flags[FLAG_N];
    c = flags[FLAG_C];
    case (cond)
      COND_ALWAYS: cond_true = 1'b1;
      COND_EQ:     cond_true = z;
      COND_NE:     cond_true = !z;
      COND_GT:     cond_true = !z && !n;
      COND_GE:     cond_true = !n;
      COND_LT:     cond_true = n;
      COND_LE:     cond_true = z || n;
      COND_CS:     cond_true = c;
      default:     cond_true = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. sp has one extra bit so that full and empty are distinct;
// the entry storage itself is not reset.
module ret_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int PC_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(STACK_DEPTH);

  logic [PC_W-1:0] mem_r [STACK_DEPTH];
  logic [AW:0]     sp_r;
  logic [AW-1:0]   top_idx_s;

  assign full      = (sp_r == (AW+1)'(STACK_DEPTH));
  assign empty     = (sp_r == (AW+1)'(0));
  assign top_idx_s = sp_r[AW-1:0] - AW'(1);
  assign top_data  = mem_r[top_idx_s];

  // Stack pointer: push and pop are mutually exclusive from the sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_r <= (AW+1)'(0);
    end else if (push && !full) begin
      sp_r <= sp_r + (AW+1)'(1);
    end else if (pop && !empty) begin
      sp_r <= sp_r - (AW+1)'(1);
    end else begin
      sp_r <= sp_r;
    end
  end

  // Entry storage written at the current stack pointer.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[sp_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: sequential fetch, conditional jumps, CALL/RET via
// the return stack, stall and halt with sticky stack error flags.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt,
  input  logic            jmp_en,
  input  logic [2:0]      jmp_cond,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] target,
  input  logic [3:0]      flags,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            halted,
  output logic            stack_overflow,
  output logic            stack_underflow
);

  state_t          state_r;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] stack_top_s;
  logic            ovf_r;
  logic            unf_r;
  logic            run_s;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;
  logic            jmp_take_s;
  logic            unused_s;

  // run_s is true only when ret/call/jmp/increment may act this cycle.
  assign run_s      = (state_r == ST_RUN) && !stall && !halt;
  assign pop_s      = run_s && ret && !empty_s;
  assign push_s     = run_s && !ret && call && !full_s;
  assign pc_inc_s   = pc_r + PC_W'(1);
  assign jmp_take_s = jmp_en && cond_true(jmp_cond, flags);
  assign unused_s   = flags[FLAG_V];

  ret_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .PC_W        (PC_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_inc_s),
    .top_data  (stack_top_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Sequencer FSM and next-PC selection in priority order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      pc_r    <= PC_W'(0);
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (stall) begin
            pc_r <= pc_r;
          end else if (halt) begin
            state_r <= ST_HALT;
          end else if (ret) begin
            if (empty_s) begin
              unf_r   <= 1'b1;
              state_r <= ST_HALT;
            end else begin
              pc_r <= stack_top_s;
            end
          end else if (call) begin
            if (full_s) begin
              ovf_r   <= 1'b1;
              state_r <= ST_HALT;
            end else begin
              pc_r <= target;
            end
          end else if (jmp_take_s) begin
            pc_r <= target;
          end else begin
            pc_r <= pc_inc_s;
          end
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          state_r <= ST_HALT;
        end
      endcase
    end
  end

  assign pc              = pc_r;
  assign pc_valid        = (state_r == ST_RUN) && !stall;
  assign halted          = (state_r == ST_HALT);
  assign stack_overflow  = ovf_r;
  assign stack_underflow = unf_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table through a scoreboard queue,
// plus hand-built overflow, underflow, halt and asynchronous reset sequences.
module tb_pc_sequencer;

  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] STL  = 5'b10000;
  localparam logic [4:0] HLT  = 5'b01000;
  localparam logic [4:0] JMP  = 5'b00100;
  localparam logic [4:0] CAL  = 5'b00010;
  localparam logic [4:0] RET  = 5'b00001;

  logic       clk = 1'b0;
  logic       rst, stall, halt, jmp_en, call, ret;
  logic [2:0] jmp_cond;
  logic [7:0] target;
  logic [3:0] flags;
  logic [7:0] pc;
  logic       pc_valid, halted, stack_overflow, stack_underflow;

  typedef struct {
    logic [4:0] ctl;
    logic [2:0] cond;
    logic [7:0] tgt;
    logic [3:0] fl;
    logic [7:0] exp_pc;
    logic [2:0] exp_st;
  } vec_t;

  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] st;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[35];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic model_halted = 1'b0;

  pc_sequencer #(.PC_W(8), .STACK_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .halt            (halt),
    .jmp_en          (jmp_en),
    .jmp_cond        (jmp_cond),
    .call            (call),
    .ret             (ret),
    .target          (target),
    .flags           (flags),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .halted          (halted),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [4:0] ctl, input logic [2:0] cond,
                              input logic [7:0] tgt, input logic [3:0] fl,
                              input logic [7:0] epc, input logic [2:0] est);
    vec_t v;
    v.ctl = ctl; v.cond = cond; v.tgt = tgt; v.fl = fl;
    v.exp_pc = epc; v.exp_st = est;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    {stall, halt, jmp_en, call, ret} = v.ctl;
    jmp_cond = v.cond;
    target   = v.tgt;
    flags    = v.fl;
    #1;
    check("pc_valid", idx, 32'(pc_valid), 32'(!model_halted && !v.ctl[4]));
    sb_q.push_back('{pc: v.exp_pc, st: v.exp_st});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("pc", idx, 32'(pc), 32'(e.pc));
    check("halted", idx, 32'(halted), 32'(e.st[2]));
    check("overflow", idx, 32'(stack_overflow), 32'(e.st[1]));
    check("underflow", idx, 32'(stack_underflow), 32'(e.st[0]));
    model_halted = e.st[2];
  endtask

  task automatic do_reset(input int idx);
    {stall, halt, jmp_en, call, ret} = IDLE;
    jmp_cond = 3'd0; target = 8'h00; flags = 4'h0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_halted = 1'b0;
    check("rst_pc", idx, 32'(pc), 32'h0);
    check("rst_halted", idx, 32'(halted), 32'h0);
    check("rst_flags", idx, 32'({stack_overflow, stack_underflow}), 32'h0);
  endtask

  task automatic async_reset(input int idx);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_pc", idx, 32'(pc), 32'h0);
    check("async_halted", idx, 32'(halted), 32'h0);
    check("async_flags", idx, 32'({stack_overflow, stack_underflow}), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_halted = 1'b0;
  endtask

  initial begin
    // Fetch, conditional jumps, wrap, call/return, stall and RET-over-JMP priority.
    tbl[0]  = mk(IDLE, 3'd0, 8'h00, 4'b0000, 8'h01, 3'b000);
    tbl[1]  = mk(IDLE, 3'd0, 8'h00, 4'b0000, 8'h02, 3'b000);
    tbl[2]  = mk(IDLE, 3'd0, 8'h00, 4'b0000, 8'h03, 3'b000);
    tbl[3]  = mk(JMP,  3'd1, 8'h20, 4'b0000, 8'h04, 3'b000);
    tbl[4]  = mk(JMP,  3'd0, 8'h03, 4'b0000, 8'h03, 3'b000);
    tbl[5]  = mk(JMP,  3'd1, 8'h20, 4'b1000, 8'h20, 3'b000);
    tbl[6]  = mk(JMP,  3'd3, 8'h50, 4'b0100, 8'h21, 3'b000);
    tbl[7]  = mk(JMP,  3'd3, 8'h50, 4'b0000, 8'h50, 3'b000);
    tbl[8]  = mk(JMP,  3'd2, 8'h60, 4'b1000, 8'h51, 3'b000);
    tbl[9]  = mk(JMP,  3'd4, 8'h60, 4'b0000, 8'h60, 3'b000);
    tbl[10] = mk(JMP,  3'd5, 8'h70, 4'b0000, 8'h61, 3'b000);
    tbl[11] = mk(JMP,  3'd6, 8'h70, 4'b1000, 8'h70, 3'b000);
    tbl[12] = mk(JMP,  3'd7, 8'h80, 4'b0001, 8'h71, 3'b000);
    tbl[13] = mk(JMP,  3'd7, 8'h80, 4'b0010, 8'h80, 3'b000);
    tbl[14] = mk(JMP,  3'd0, 8'hFF, 4'b0000, 8'hFF, 3'b000);
    tbl[15] = mk(IDLE, 3'd0, 8'h00, 4'b0000, 8'h00, 3'b000);
    tbl[16] = mk(JMP,  3'd0, 8'h10, 4'b0000, 8'h10, 3'b000);
    tbl[17] = mk(CAL,  3'd0, 8'h40, 4'b0000, 8'h40, 3'b000);
    tbl[18] = mk(IDLE, 3'd0, 8'h00, 4'b0000, 8'h41, 3'b000);
    tbl[19] = mk(IDLE, 3'd0, 8'h00, 4'b0000, 8'h42, 3'b000);
    tbl[20] = mk(RET,  3'd0, 8'h00, 4'b0000, 8'h11, 3'b000);
    tbl[21] = mk(CAL,  3'd0, 8'h30, 4'b0000, 8'h30, 3'b000);
    tbl[22] = mk(CAL,  3'd0, 8'h50, 4'b0000, 8'h50, 3'b000);
    tbl[23] = mk(CAL,  3'd0, 8'h70, 4'b0000, 8'h70, 3'b000);
    tbl[24] = mk(RET,  3'd0, 8'h00, 4'b0000, 8'h51, 3'b000);
    tbl[25] = mk(RET,  3'd0, 8'h00, 4'b0000, 8'h31, 3'b000);
    tbl[26] = mk(RET,  3'd0, 8'h00, 4'b0000, 8'h12, 3'b000);
    tbl[27] = mk(STL | CAL, 3'd0, 8'h90, 4'b0000, 8'h12, 3'b000);
    tbl[28] = mk(STL | CAL, 3'd0, 8'h90, 4'b0000, 8'h12, 3'b000);
    tbl[29] = mk(STL | CAL, 3'd0, 8'h90, 4'b0000, 8'h12, 3'b000);
    tbl[30] = mk(CAL,  3'd0, 8'h90, 4'b0000, 8'h90, 3'b000);
    tbl[31] = mk(RET | JMP, 3'd0, 8'hA0, 4'b0000, 8'h13, 3'b000);
    tbl[32] = mk(JMP,  3'd0, 8'hFF, 4'b0000, 8'hFF, 3'b000);
    tbl[33] = mk(CAL,  3'd0, 8'h05, 4'b0000, 8'h05, 3'b000);
    tbl[34] = mk(RET,  3'd0, 8'h00, 4'b0000, 8'h00, 3'b000);

    do_reset(0);
    for (int i = 0; i < 35; i++) step(tbl[i], i);

    // Overflow: five CALLs to the same target, the fifth halts with pc held.
    do_reset(1);
    for (int i = 0; i < 4; i++) step(mk(CAL, 3'd0, 8'h40, 4'b0000, 8'h40, 3'b000), 100 + i);
    step(mk(CAL,  3'd0, 8'h40, 4'b0000, 8'h40, 3'b110), 104);
    step(mk(IDLE, 3'd0, 8'h00, 4'b0000, 8'h40, 3'b110), 105);
    async_reset(1);

    // Underflow: RET on an empty stack.
    do_reset(2);
    step(mk(RET,  3'd0, 8'h00, 4'b0000, 8'h00, 3'b101), 200);
    step(mk(IDLE, 3'd0, 8'h00, 4'b0000, 8'h00, 3'b101), 201);
    async_reset(2);

    // Halt beats a simultaneous CALL, then the frozen pc ignores all controls.
    do_reset(3);
    step(mk(IDLE, 3'd0, 8'h00, 4'b0000, 8'h01, 3'b000), 300);
    step(mk(IDLE, 3'd0, 8'h00, 4'b0000, 8'h02, 3'b000), 301);
    step(mk(HLT | CAL, 3'd0, 8'h33, 4'b0000, 8'h02, 3'b100), 302);
    for (int i = 0; i < 10; i++) begin
      step(mk((i % 2 == 0) ? JMP : CAL, 3'd0, 8'hAA, 4'b1111, 8'h02, 3'b100), 310 + i);
    end
    async_reset(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
